// File: rtl/press_pkg.sv
// Shared definitions for the press classifier: default timing parameters,
// counter width and FSM state encoding.
package press_pkg;

  localparam int unsigned TICK_DIV_DEF  = 50000;
  localparam int unsigned LONG_MS_DEF   = 1000;
  localparam int unsigned DCLICK_MS_DEF = 300;

  localparam int unsigned MS_W    = 16;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ENC_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ENC_PRESS1    = 3'd1;
  localparam logic [STATE_W-1:0] ENC_GAP       = 3'd2;
  localparam logic [STATE_W-1:0] ENC_PRESS2    = 3'd3;
  localparam logic [STATE_W-1:0] ENC_LONG_HELD = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = ENC_IDLE,
    ST_PRESS1    = ENC_PRESS1,
    ST_GAP       = ENC_GAP,
    ST_PRESS2    = ENC_PRESS2,
    ST_LONG_HELD = ENC_LONG_HELD
  } state_t;

endpackage

// File: rtl/ms_timer.sv
// Millisecond timer: a 0..TICK_DIV-1 prescaler feeding a saturating 16-bit
// ms counter, both cleared synchronously by i_clr.
module ms_timer
  import press_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  output logic [MS_W-1:0] o_ms_cnt
);

  localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [MS_W-1:0]  r_ms;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (i_clr) begin
      r_pre <= '0;
      r_ms  <= '0;
    end else if (r_pre == PRE_LAST) begin
      r_pre <= '0;
      if (r_ms != '1) r_ms <= r_ms + MS_W'(1);
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign o_ms_cnt = r_ms;

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double-click
// events; each event is a registered one-cycle pulse.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned DCLICK_MS = DCLICK_MS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic busy
);

  localparam logic [MS_W-1:0] LONG_CNT   = MS_W'(LONG_MS);
  localparam logic [MS_W-1:0] DCLICK_CNT = MS_W'(DCLICK_MS);

  state_t          r_state;
  state_t          w_next;
  logic            w_short;
  logic            w_long;
  logic            w_double;
  logic            w_clr;
  logic [MS_W-1:0] w_ms_cnt;
  logic            r_short;
  logic            r_long;
  logic            r_double;
  logic            r_busy;

  ms_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_ms_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_clr),
    .o_ms_cnt (w_ms_cnt)
  );

  // Level changes are tested before timer expiry so they win ties.
  always_comb begin
    w_next   = r_state;
    w_short  = 1'b0;
    w_long   = 1'b0;
    w_double = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (db_level) w_next = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (!db_level) begin
          w_next = ST_GAP;
        end else if (w_ms_cnt == LONG_CNT) begin
          w_next = ST_LONG_HELD;
          w_long = 1'b1;
        end
      end
      ST_GAP: begin
        if (db_level) begin
          w_next = ST_PRESS2;
        end else if (w_ms_cnt == DCLICK_CNT) begin
          w_next  = ST_IDLE;
          w_short = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (!db_level) begin
          w_next   = ST_IDLE;
          w_double = 1'b1;
        end else if (w_ms_cnt == LONG_CNT) begin
          w_next = ST_LONG_HELD;
          w_long = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!db_level) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_clr = (w_next != r_state);

  // busy is registered from the next state so it tracks the state register exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_busy   <= (w_next != ST_IDLE);
    end
  end

  assign short_tick  = r_short;
  assign long_tick   = r_long;
  assign double_tick = r_double;
  assign busy        = r_busy;

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: directed scenarios plus a random
// level pattern, all compared against a cycle-count reference model.
module tb_press_classifier;

  localparam int unsigned TB_TICK_DIV  = 4;
  localparam int unsigned TB_LONG_MS   = 5;
  localparam int unsigned TB_DCLICK_MS = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_DOWN1 = 1;
  localparam int PH_UP    = 2;
  localparam int PH_DOWN2 = 3;
  localparam int PH_HOLD  = 4;

  logic clk = 1'b0;
  logic reset;
  logic db_level;
  logic short_tick;
  logic long_tick;
  logic double_tick;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  int m_ph;
  int m_elapsed;
  bit m_short, m_long, m_double;

  logic p_short, p_long, p_double;
  int   cnt_short, cnt_long, cnt_double;

  press_classifier #(
    .TICK_DIV  (TB_TICK_DIV),
    .LONG_MS   (TB_LONG_MS),
    .DCLICK_MS (TB_DCLICK_MS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_level    (db_level),
    .short_tick  (short_tick),
    .long_tick   (long_tick),
    .double_tick (double_tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: whole ms elapsed = cycles spent in the current phase / TICK_DIV.
  task automatic model_step(input logic lvl);
    int ms;
    int nph;
    ms = m_elapsed / int'(TB_TICK_DIV);
    if (ms > 65535) ms = 65535;
    nph = m_ph;
    m_short = 0; m_long = 0; m_double = 0;
    if (m_ph == PH_IDLE) begin
      if (lvl) nph = PH_DOWN1;
    end else if (m_ph == PH_DOWN1 || m_ph == PH_DOWN2) begin
      if (!lvl) begin
        nph = (m_ph == PH_DOWN1) ? PH_UP : PH_IDLE;
        m_double = (m_ph == PH_DOWN2);
      end else if (ms == int'(TB_LONG_MS)) begin
        nph = PH_HOLD; m_long = 1;
      end
    end else if (m_ph == PH_UP) begin
      if (lvl) nph = PH_DOWN2;
      else if (ms == int'(TB_DCLICK_MS)) begin
        nph = PH_IDLE; m_short = 1;
      end
    end else begin
      if (!lvl) nph = PH_IDLE;
    end
    if (nph != m_ph) m_elapsed = 0;
    else if (m_elapsed < 1000000) m_elapsed++;
    m_ph = nph;
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_elapsed = 0;
    m_short = 0; m_long = 0; m_double = 0;
    p_short = 0; p_long = 0; p_double = 0;
  endtask

  task automatic clear_counts();
    cnt_short = 0; cnt_long = 0; cnt_double = 0;
  endtask

  // One clock: drive level, advance the model, compare just after the edge.
  task automatic step(input logic lvl);
    db_level = lvl;
    @(posedge clk);
    model_step(lvl);
    #1;
    check("short_tick", 32'(short_tick), 32'(m_short));
    check("long_tick", 32'(long_tick), 32'(m_long));
    check("double_tick", 32'(double_tick), 32'(m_double));
    check("busy", 32'(busy), 32'(m_ph != PH_IDLE));
    check("at_most_one_event", 32'((int'(short_tick) + int'(long_tick) + int'(double_tick)) <= 1), 32'd1);
    check("pulse_width", 32'((short_tick & p_short) | (long_tick & p_long) | (double_tick & p_double)), 32'd0);
    p_short = short_tick; p_long = long_tick; p_double = double_tick;
    cnt_short  += int'(short_tick);
    cnt_long   += int'(long_tick);
    cnt_double += int'(double_tick);
  endtask

  task automatic apply_reset(input logic lvl, input int cycles);
    reset = 1'b1;
    db_level = lvl;
    model_reset();
    #1;
    check("reset_async_outputs", {28'd0, short_tick, long_tick, double_tick, busy}, 32'd0);
    repeat (cycles) @(posedge clk);
    #1;
    check("reset_held_outputs", {28'd0, short_tick, long_tick, double_tick, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl);
  endtask

  initial begin
    int short_at, long_at, dbl_at, busy_ok, done;
    reset = 1'b1;
    db_level = 1'b0;
    model_reset();
    clear_counts();
    @(negedge clk);
    apply_reset(1'b0, 3);
    run_level(1'b0, 3);

    // Single short press: 8 cycles high, then release.
    clear_counts();
    short_at = -1;
    run_level(1'b1, 8);
    for (int k = 0; k < 20; k++) begin
      step(1'b0);
      if (short_tick) short_at = k;
    end
    check("short_latency", 32'(short_at), 32'd13);
    check("short_count", 32'(cnt_short), 32'd1);
    check("short_no_other", 32'(cnt_long + cnt_double), 32'd0);

    // Long hold: 40 cycles high.
    clear_counts();
    long_at = -1;
    busy_ok = 1;
    for (int k = 0; k < 40; k++) begin
      step(1'b1);
      if (long_tick) long_at = k;
      if (!busy) busy_ok = 0;
    end
    check("long_latency", 32'(long_at), 32'd21);
    check("long_busy_held", 32'(busy_ok), 32'd1);
    step(1'b0);
    check("long_busy_release", 32'(busy), 32'd0);
    check("long_count", 32'(cnt_long), 32'd1);
    check("long_no_other", 32'(cnt_short + cnt_double), 32'd0);
    run_level(1'b0, 20);

    // Double click: press 6, release 5, press 6, release.
    clear_counts();
    run_level(1'b1, 6);
    run_level(1'b0, 5);
    run_level(1'b1, 6);
    step(1'b0);
    check("double_after_release", 32'(double_tick), 32'd1);
    run_level(1'b0, 20);
    check("double_count", 32'(cnt_double), 32'd1);
    check("double_no_short", 32'(cnt_short + cnt_long), 32'd0);

    // Re-press arrives exactly when the gap timer expires: press wins.
    clear_counts();
    run_level(1'b1, 2);
    run_level(1'b0, 13);
    step(1'b1);
    check("tie_no_short", 32'(cnt_short), 32'd0);
    check("tie_busy", 32'(busy), 32'd1);
    step(1'b1);
    step(1'b0);
    check("tie_reached_press2", 32'(double_tick), 32'd1);
    run_level(1'b0, 20);
    check("tie_short_total", 32'(cnt_short), 32'd0);

    // Reset while in the second press aborts the sequence silently.
    clear_counts();
    run_level(1'b1, 3);
    run_level(1'b0, 2);
    run_level(1'b1, 2);
    check("pre_reset_busy", 32'(busy), 32'd1);
    apply_reset(1'b0, 2);
    run_level(1'b0, 30);
    check("after_reset_no_event", 32'(cnt_short + cnt_long + cnt_double), 32'd0);

    // Button held through reset release enters the first press immediately.
    apply_reset(1'b1, 2);
    check("held_reset_idle", 32'(busy), 32'd0);
    step(1'b1);
    check("held_release_busy", 32'(busy), 32'd1);
    run_level(1'b0, 20);

    // Random level pattern of 200 cycles in runs of varied length.
    clear_counts();
    done = 0;
    dbl_at = 0;
    while (done < 200) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 26));
      if (done + len > 200) len = 200 - done;
      run_level(lvl, len);
      done += len;
      dbl_at++;
    end
    check("random_steps", 32'(done), 32'd200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clk cycles per 1 ms tick (50 MHz clock).
REQ-002 The block SHALL have parameter LONG_MS, default 1000, meaning hold time in ms that classifies a long press.
REQ-003 The block SHALL have parameter DCLICK_MS, default 300, meaning the maximum release-to-press gap in ms for a double click.
REQ-004 The block SHALL have port clk, input, 1, the clock.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port db_level, input, 1, the debounced button level, synchronous to clk, 1 = pressed.
REQ-007 The block SHALL have port short_tick, output, 1, a one-cycle pulse on a single short press.
REQ-008 The block SHALL have port long_tick, output, 1, a one-cycle pulse when a hold reaches LONG_MS.
REQ-009 The block SHALL have port double_tick, output, 1, a one-cycle pulse on a completed double click.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 The ms timer SHALL use a prescaler counting 0..TICK_DIV-1, with ms_cnt (16 bit, saturating at all-ones) incrementing when the prescaler reaches TICK_DIV-1.
REQ-012 The prescaler and ms_cnt SHALL both clear to 0 on every state transition.
REQ-013 The FSM SHALL have the states IDLE, PRESS1, GAP, PRESS2 and LONG_HELD.
REQ-014 In IDLE, db_level=1 SHALL cause a move to PRESS1.
REQ-015 In PRESS1, db_level=0 SHALL cause a move to GAP; otherwise ms_cnt==LONG_MS SHALL cause a move to LONG_HELD with long_tick.
REQ-016 In GAP, db_level=1 SHALL cause a move to PRESS2; otherwise ms_cnt==DCLICK_MS SHALL cause a move to IDLE with short_tick.
REQ-017 In PRESS2, db_level=0 SHALL cause a move to IDLE with double_tick; otherwise ms_cnt==LONG_MS SHALL cause a move to LONG_HELD with long_tick and no double_tick.
REQ-018 In LONG_HELD, db_level=0 SHALL cause a move to IDLE, with no pulse.
REQ-019 Simultaneous events SHALL be resolved with the db_level change taking priority over timer expiry (PRESS1 → GAP; GAP → PRESS2; PRESS2 → double_tick).
REQ-020 Event outputs SHALL be registered, each asserted for exactly the one clk cycle after the transitioning edge, i.e. the first cycle in the destination state.
REQ-021 At most one event output SHALL be high in any cycle.
REQ-022 Each press sequence SHALL yield at most one event.
REQ-023 busy SHALL be a registered decode of the state register, with no combinational path from db_level.
REQ-024 Any undefined state encoding SHALL return to IDLE on the next clk edge without generating a pulse.
REQ-025 The block SHALL require LONG_MS ≥ 1, DCLICK_MS ≥ 1, TICK_DIV ≥ 2, and LONG_MS, DCLICK_MS < 65535.

Reset
REQ-026 reset SHALL asynchronously force state=IDLE, prescaler=0, ms_cnt=0 and short_tick=long_tick=double_tick=busy=0.
REQ-027 A reset asserted mid-sequence (any state) SHALL abort the sequence with no event emitted, either during reset or after its release.
REQ-028 If db_level is 1 when reset is released, PRESS1 SHALL be entered on the first clk edge after release.

Structure
REQ-029 The state encoding localparams and the default TICK_DIV, LONG_MS and DCLICK_MS values SHALL reside in a shared package, press_pkg.
REQ-030 The prescaler plus ms_cnt, with a clear input and a count output, SHALL be one sub-module, ms_timer, instantiated once.
REQ-031 The FSM, output registers and busy decode SHALL reside in press_classifier.
REQ-032 The block SHALL sit downstream of the debouncer FSM; db_level connects directly to its db output.

Verification (TICK_DIV=4, LONG_MS=5, DCLICK_MS=3)
REQ-033 A bench SHALL drive db_level high 8 cycles then low, and check that short_tick pulses once, ~12 cycles after release, with long_tick=double_tick=0.
REQ-034 A bench SHALL hold db_level high 40 cycles, and check that long_tick pulses once ~20 cycles after press, that busy stays 1 until release, and that busy=0 on the cycle after release.
REQ-035 A bench SHALL drive press 6 cycles, release 5, press 6, release, and check that double_tick pulses exactly once on the cycle after the second release, with no short_tick.
REQ-036 A bench SHALL make db_level rise in GAP on the same cycle that ms_cnt reaches 3, and check that the state goes to PRESS2 with no short_tick.
REQ-037 A bench SHALL assert reset for 2 cycles while in PRESS2, and check that all outputs are 0 and no event follows the release of reset.
REQ-038 A bench SHALL apply a 200-cycle random db_level pattern and check the assertion that at most one event output is high per cycle and that each pulse lasts exactly 1 cycle.
